alu_result_pipe: RTL and testbench

//  Registered output stage directly downstream of the W-bit add/sub unit.

---
 rtl/alu_result_pipe.sv | 127 ++++++++++++
 tb/tb_alu_result_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_pipe.sv
// Registered 2-entry skid stage behind the add/sub unit: result + flags, sticky status, delivery count.
// Optional sticky overflow/borrow status is built only when ALU_STICKY_FLAGS_EN is defined.
module alu_result_pipe #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_y,
   input  logic          in_carry,
   input  logic          in_ovf,
   input  logic          in_zero,
   input  logic          in_neg,
   input  logic          in_sub,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_y,
   output logic [3:0]    out_flags,
   input  logic          sticky_clr,
   output logic          sticky_ovf,
   output logic          sticky_brw,
   output logic [CW-1:0] out_count
);

   // state | meaning
   // EMPTY | no entries held
   // ONE   | head entry valid, skid empty
   // FULL  | head and skid both valid, upstream stalled
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t         state, state_nxt;
   logic [W+3:0]   head, head_nxt;
   logic [W+3:0]   skid, skid_nxt;
   logic [W+3:0]   entry_in;
   logic           ready_q;
   logic           accept;
   logic           deliver;

   assign entry_in  = {in_y, in_carry, in_ovf, in_zero, in_neg};
   assign accept    = in_valid & ready_q;
   assign deliver   = (state != EMPTY) & out_ready;
   assign in_ready  = ready_q;
   assign out_valid = (state != EMPTY);
   assign out_y     = head[W+3:4];
   assign out_flags = head[3:0];

   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      skid_nxt  = skid;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               head_nxt  = entry_in;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               head_nxt = entry_in;
            end else if (accept) begin
               state_nxt = FULL;
               skid_nxt  = entry_in;
            end else if (deliver) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (deliver) begin
               state_nxt = ONE;
               head_nxt  = skid;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // in_ready is registered from the next state so out_ready never reaches it combinationally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         head      <= '0;
         skid      <= '0;
         ready_q   <= 1'b1;
         out_count <= '0;
      end else begin
         state   <= state_nxt;
         head    <= head_nxt;
         skid    <= skid_nxt;
         ready_q <= (state_nxt != FULL);
         if (deliver)
            out_count <= out_count + 1'b1;
      end
   end

`ifdef ALU_STICKY_FLAGS_EN
   logic ovf_q, brw_q;

   // a setting accept wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         brw_q <= 1'b0;
      end else begin
         if (accept && in_ovf)
            ovf_q <= 1'b1;
         else if (sticky_clr)
            ovf_q <= 1'b0;
         if (accept && in_sub && !in_carry)
            brw_q <= 1'b1;
         else if (sticky_clr)
            brw_q <= 1'b0;
      end
   end

   assign sticky_ovf = ovf_q;
   assign sticky_brw = brw_q;
`else
   logic unused_sticky;
   assign unused_sticky = sticky_clr ^ in_sub;
   assign sticky_ovf    = 1'b0;
   assign sticky_brw    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_pipe.sv
// Bench for alu_result_pipe: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_result_pipe;

`ifdef ALU_STICKY_FLAGS_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_y = '0;
   logic        in_carry = 1'b0, in_ovf = 1'b0, in_zero = 1'b0, in_neg = 1'b0, in_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_y;
   logic [3:0]  out_flags;
   logic        sticky_clr = 1'b0;
   logic        sticky_ovf, sticky_brw;
   logic [15:0] out_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   alu_result_pipe #(.W(8), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_carry(in_carry), .in_ovf(in_ovf), .in_zero(in_zero),
      .in_neg(in_neg), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_flags(out_flags),
      .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .sticky_brw(sticky_brw),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   // reference model: FIFO of at most two entries, counter, sticky bits, delivered-Y log
   logic [11:0] mq[$];
   logic [7:0]  dlog[$];
   logic [15:0] m_cnt = '0;
   logic        m_ovf = 1'b0, m_brw = 1'b0;

   always @(posedge clk) begin
      bit acc, del;
      if (!rst_n) begin
         mq.delete();
         dlog.delete();
         m_cnt = '0;
         m_ovf = 1'b0;
         m_brw = 1'b0;
      end else begin
         acc = in_valid && (mq.size() < 2);
         del = (mq.size() > 0) && out_ready;
         if (STICKY) begin
            if (acc && in_ovf) m_ovf = 1'b1;
            else if (sticky_clr) m_ovf = 1'b0;
            if (acc && in_sub && !in_carry) m_brw = 1'b1;
            else if (sticky_clr) m_brw = 1'b0;
         end
         if (del) begin
            dlog.push_back(mq[0][11:4]);
            void'(mq.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (acc) mq.push_back({in_y, in_carry, in_ovf, in_zero, in_neg});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
         chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
         if (mq.size() != 0) begin
            chk("out_y", {24'd0, out_y}, {24'd0, mq[0][11:4]});
            chk("out_flags", {28'd0, out_flags}, {28'd0, mq[0][3:0]});
         end
         chk("out_count", {16'd0, out_count}, {16'd0, m_cnt});
         chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_ovf});
         chk("sticky_brw", {31'd0, sticky_brw}, {31'd0, m_brw});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [7:0] y, input logic c, input logic o, input logic z,
                        input logic n, input logic s);
      in_valid = 1'b1;
      in_y = y; in_carry = c; in_ovf = o; in_zero = z; in_neg = n; in_sub = s;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_y = '0; in_carry = 1'b0; in_ovf = 1'b0; in_zero = 1'b0; in_neg = 1'b0; in_sub = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         if (in_ready) done = 1'b1;
         step();
      end
      idle();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout actual=no_accept required=accept", name);
      end
   endtask

   initial begin
      // 1: reset held two cycles with in_valid high
      drive(8'hAA, 1, 1, 0, 1, 1);
      rst_n = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      idle();
      rst_n = 1'b1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_y", {24'd0, out_y}, 32'd0);
      chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
      chk("rst_count", {16'd0, out_count}, 32'd0);
      chk("rst_sticky", {30'd0, sticky_ovf, sticky_brw}, 32'd0);

      // 2: pass-through
      out_ready = 1'b1;
      drive(8'h7F, 0, 0, 0, 0, 0);
      step();
      chk("pt_first_y", {24'd0, out_y}, 32'h7F);
      drive(8'h80, 0, 1, 0, 1, 0);
      step();
      chk("pt_second_y", {24'd0, out_y}, 32'h80);
      chk("pt_second_flags", {28'd0, out_flags}, 32'b0101);
      idle();
      step();
      step();
      chk("pt_count", {16'd0, out_count}, 32'd2);
      chk("pt_sticky_ovf", {31'd0, sticky_ovf}, {31'd0, STICKY});
      chk("pt_log_size", dlog.size(), 32'd2);
      if (dlog.size() == 2) begin
         chk("pt_log0", {24'd0, dlog[0]}, 32'h7F);
         chk("pt_log1", {24'd0, dlog[1]}, 32'h80);
      end

      // 3: backpressure
      do_reset();
      out_ready = 1'b0;
      drive(8'h11, 1, 0, 0, 0, 0);
      step();
      drive(8'h22, 0, 0, 0, 0, 0);
      step();
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      drive(8'h33, 0, 0, 1, 0, 0);
      step();
      step();
      chk("bp_head_held", {24'd0, out_y}, 32'h11);
      out_ready = 1'b1;
      wait_accept("bp_accept_33");
      repeat (3) step();
      chk("bp_log_size", dlog.size(), 32'd3);
      if (dlog.size() == 3) begin
         chk("bp_log0", {24'd0, dlog[0]}, 32'h11);
         chk("bp_log1", {24'd0, dlog[1]}, 32'h22);
         chk("bp_log2", {24'd0, dlog[2]}, 32'h33);
      end
      chk("bp_count", {16'd0, out_count}, 32'd3);

      // 4: borrow sticky
      do_reset();
      out_ready = 1'b1;
      drive(8'hFF, 0, 0, 0, 1, 1);
      step();
      chk("brw_set", {31'd0, sticky_brw}, {31'd0, STICKY});
      sticky_clr = 1'b1;
      step();
      chk("brw_set_wins", {31'd0, sticky_brw}, {31'd0, STICKY});
      idle();
      step();
      chk("brw_cleared", {31'd0, sticky_brw}, 32'd0);
      sticky_clr = 1'b0;
      drive(8'h05, 1, 0, 0, 0, 1);
      step();
      idle();
      chk("brw_sub_carry_no_set", {31'd0, sticky_brw}, 32'd0);
      step();

      // 5: counter wrap
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         drive(i[7:0], 0, 0, 0, 0, 0);
         step();
      end
      idle();
      step();
      chk("wrap_ffff", {16'd0, out_count}, 32'hFFFF);
      drive(8'h5A, 0, 0, 0, 0, 0);
      step();
      idle();
      step();
      chk("wrap_zero", {16'd0, out_count}, 32'h0000);

      // 6: reset while FULL
      do_reset();
      out_ready = 1'b0;
      drive(8'h11, 0, 0, 0, 0, 0);
      step();
      drive(8'h22, 0, 0, 0, 0, 0);
      step();
      idle();
      chk("mid_full", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_log_empty", dlog.size(), 32'd0);
      chk("mid_count", {16'd0, out_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
